bicintp_rd_ctrl: RTL and testbench
==================================

# bicintp_rd_ctrl

Read-side scheduler for the 8-row bicubic line buffer, in the sys_clk domain between the line buffer and the bicubic arithmetic. For each output line it requests from the display side, it advances the 4-row vertical window with one-cycle row-advance pulses and scans the buffer with four horizontal tap reads per output pixel. It also forwards tap tags and fractional weights, aligned to the RAM read latency, to the interpolation calculator.

## Interface
- SRC_W, 640, source pixels per row
- SRC_H, 480, source rows per frame
- OUT_W, 1024, output pixels per line
- OUT_H, 768, output lines per frame
- FRAC, 8, fractional bits of coordinate accumulators
- RD_LAT, 3, line-buffer read latency in sys_clk cycles
- sys_clk  in  1  system clock, 125 MHz; sole clock
- sys_rst  in  1  reset, synchronous, active-high
- frame_start  in  1  1-cycle pulse, new source frame (vsync already synchronised to sys_clk)
- line_req  in  1  1-cycle pulse, display side requests next output line
- ram_ready  in  1  line buffer has the next source row available
- ram_rd_enb  out  1  buffer read enable
- ram_rd_addr  out  10  buffer column address
- ram_rd_sel  out  1  1-cycle pulse, advance window by one source row
- tap_vld  out  1  p0..p3 of the buffer valid this cycle
- tap_idx  out  2  horizontal tap 0..3 (column xi-1..xi+2)
- tap_fx  out  FRAC  horizontal fraction of the current pixel
- tap_fy  out  FRAC  vertical fraction of the current line
- tap_sol / tap_eol  out  1  first tap of pixel 0 / last tap of pixel OUT_W-1
- busy  out  1  a line is being produced
- err_ovr  out  1  sticky; line_req arrived while busy. Cleared by frame_start.

## Operation
- Constants: STEP_X = (SRC_W<<FRAC)/OUT_W, STEP_Y = (SRC_H<<FRAC)/OUT_H, truncated. Accumulators are 10+FRAC bits wide: x_acc, y_acc. Integer part xi/yi is the upper 10 bits; fraction fx/fy is the lower FRAC bits.
- win_row: source row at window position p1. frame_start sets win_row=0, y_acc=0, line_cnt=0 and returns to IDLE from any state.
- FSM states:
  - IDLE: on line_req, go to ADV.
  - ADV: if yi > win_row and ram_ready, pulse ram_rd_sel, win_row++, go to GAP. If yi > win_row and !ram_ready, stay. If yi <= win_row, go to WAIT_RDY.
  - GAP: one cycle so ram_ready reflects the advance, then go to ADV.
  - WAIT_RDY: wait for ram_ready, then go to SCAN.
  - SCAN: issue 4 reads per pixel, taps 0..3, one per cycle. Addresses are xi-1, xi, xi+1, xi+2, each clamped to [0, SRC_W-1]. After tap 3, x_acc += STEP_X. After pixel OUT_W-1, go to DRAIN.
  - DRAIN: RD_LAT cycles, then LDONE.
  - LDONE: y_acc += STEP_Y, line_cnt++, x_acc=0. If line_cnt reaches OUT_H, line_cnt=0, stay in IDLE until frame_start.
- win_row never exceeds SRC_H-1; once there, ADV skips advance.
- line_req in any state other than IDLE sets err_ovr and is dropped.
- line_req in the same cycle as frame_start: frame_start wins, and line_req is honoured next cycle only if re-pulsed.

## Timing
- All outputs registered. Reset values: ram_rd_enb=0, ram_rd_addr=0, ram_rd_sel=0, tap_*=0, busy=0, err_ovr=0, FSM=IDLE, accumulators=0, win_row=0.
- ram_rd_sel is never asserted in consecutive cycles, and never while ram_rd_enb=1.
- tap_vld/tap_idx/tap_fx/tap_fy/sol/eol equal the issue-cycle values delayed exactly RD_LAT cycles through a shift register.
- Pixel throughput: 1 per 4 cycles. Line time with no row advance: 4*OUT_W + RD_LAT + 3 cycles from line_req to busy fall.
- busy rises the cycle after line_req and falls the cycle after LDONE.
- Synchronous reset mid-line: all state clears next edge, and tap pipeline contents are discarded (tap_vld=0).

## Structure
- Package bicintp_pkg holds the SRC_W/SRC_H/OUT_W/OUT_H defaults, the STEP_X/STEP_Y functions, and the FSM state enum shared with the calculator's bench.
- One sub-module: bicintp_tap_dly, a RD_LAT-deep tag shift register with synchronous clear.

## Test plan
- Reset, then line_req with ram_ready=1 from frame start, default parameters: line 0 produces 4096 tap_vld cycles and 0 rd_sel. First pixel addresses are 0,0,1,2. Last pixel (xi=639) addresses are 638,639,639,639.
- Full frame with ram_ready held 1: exactly 479 ram_rd_sel pulses total, never back-to-back. tap_fy on line 1 = 160 (STEP_Y=160, FRAC=8).
- ram_ready dropped for 50 cycles when ADV needs a row: no rd_sel and no reads until it rises. rd_sel appears 1 cycle after ready returns.
- line_req while busy: err_ovr=1, line output unchanged. The next frame_start clears err_ovr.
- sys_rst asserted mid-SCAN: next cycle ram_rd_enb=0 and busy=0, and no tap_vld afterwards.
- frame_start mid-line: FSM to IDLE, win_row=0. The next line_req restarts with line 0 addresses and fy=0.

Source files
------------

// File: rtl/bicintp_pkg.sv
// Shared constants, step functions and FSM state encoding for the bicubic
// line-buffer read scheduler and its companion blocks.
package bicintp_pkg;

  localparam int SRC_W_DEF  = 640;
  localparam int SRC_H_DEF  = 480;
  localparam int OUT_W_DEF  = 1024;
  localparam int OUT_H_DEF  = 768;
  localparam int FRAC_DEF   = 8;
  localparam int RD_LAT_DEF = 3;
  localparam int ADDR_W     = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADV,
    ST_GAP,
    ST_WAIT_RDY,
    ST_SCAN,
    ST_DRAIN,
    ST_LDONE
  } rd_state_e;

  function automatic int step_x(input int src_w, input int out_w, input int frac);
    return (src_w << frac) / out_w;
  endfunction

  function automatic int step_y(input int src_h, input int out_h, input int frac);
    return (src_h << frac) / out_h;
  endfunction

endpackage

// File: rtl/bicintp_rd_ctrl_if.sv
// Control, line-buffer read and tap-tag signals between the read scheduler
// (master) and its environment (slave).
interface bicintp_rd_ctrl_if
  import bicintp_pkg::*;
#(
  parameter int FRAC = FRAC_DEF
);
  logic              frame_start;
  logic              line_req;
  logic              ram_ready;
  logic              ram_rd_enb;
  logic [ADDR_W-1:0] ram_rd_addr;
  logic              ram_rd_sel;
  logic              tap_vld;
  logic [1:0]        tap_idx;
  logic [FRAC-1:0]   tap_fx;
  logic [FRAC-1:0]   tap_fy;
  logic              tap_sol;
  logic              tap_eol;
  logic              busy;
  logic              err_ovr;

  modport master (
    input  frame_start, line_req, ram_ready,
    output ram_rd_enb, ram_rd_addr, ram_rd_sel,
    output tap_vld, tap_idx, tap_fx, tap_fy, tap_sol, tap_eol,
    output busy, err_ovr
  );

  modport slave (
    output frame_start, line_req, ram_ready,
    input  ram_rd_enb, ram_rd_addr, ram_rd_sel,
    input  tap_vld, tap_idx, tap_fx, tap_fy, tap_sol, tap_eol,
    input  busy, err_ovr
  );
endinterface

// File: rtl/bicintp_tap_dly.sv
// Fixed-depth tag shift register that aligns tap tags with the line-buffer
// read latency; synchronous clear empties the whole pipe.
module bicintp_tap_dly #(
  parameter int W     = 8,
  parameter int DEPTH = 3
) (
  input  logic         sys_clk,
  input  logic         clr,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  logic [W-1:0] stage [DEPTH];

  // NOTE: every stage is cleared, not just the valid bit, so all tap tags read 0 after a clear.
  always_ff @(posedge sys_clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];
endmodule

// File: rtl/bicintp_rd_ctrl.sv
// Read-side scheduler for the 8-row bicubic line buffer: advances the 4-row
// window per output line and issues four clamped horizontal tap reads per pixel.
module bicintp_rd_ctrl
  import bicintp_pkg::*;
#(
  parameter int SRC_W  = SRC_W_DEF,
  parameter int SRC_H  = SRC_H_DEF,
  parameter int OUT_W  = OUT_W_DEF,
  parameter int OUT_H  = OUT_H_DEF,
  parameter int FRAC   = FRAC_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input logic               sys_clk,
  input logic               sys_rst,
  bicintp_rd_ctrl_if.master bus
);
  localparam int ACC_W  = ADDR_W + FRAC;
  localparam int CW     = ADDR_W + 1;
  localparam int PIX_W  = $clog2(OUT_W);
  localparam int LINE_W = $clog2(OUT_H);
  localparam int DRN_W  = $clog2(RD_LAT + 1);
  localparam int TAG_W  = 5 + 2 * FRAC;

  localparam logic [ACC_W-1:0]  STEP_X  = ACC_W'(step_x(SRC_W, OUT_W, FRAC));
  localparam logic [ACC_W-1:0]  STEP_Y  = ACC_W'(step_y(SRC_H, OUT_H, FRAC));
  localparam logic [ADDR_W-1:0] ROW_MAX = ADDR_W'(SRC_H - 1);
  localparam logic [ADDR_W-1:0] COL_MAX = ADDR_W'(SRC_W - 1);
  localparam logic [CW-1:0]     COL_LIM = CW'(SRC_W);

  rd_state_e         state;
  logic [ACC_W-1:0]  x_acc, y_acc;
  logic [ADDR_W-1:0] win_row;
  logic [LINE_W-1:0] line_cnt;
  logic [PIX_W-1:0]  pix_cnt;
  logic [1:0]        tap_cnt;
  logic [DRN_W-1:0]  drn_cnt;
  logic              frame_done;

  logic              rd_enb, rd_sel, busy, err_ovr;
  logic [ADDR_W-1:0] rd_addr;
  logic [1:0]        iss_idx;
  logic [FRAC-1:0]   iss_fx, iss_fy;
  logic              iss_sol, iss_eol;

  logic [ADDR_W-1:0] xi, yi, col_addr;
  logic [CW-1:0]     col_p1;
  logic              last_pix, need_row;

  assign xi       = x_acc[FRAC +: ADDR_W];
  assign yi       = y_acc[FRAC +: ADDR_W];
  assign last_pix = (pix_cnt == PIX_W'(OUT_W - 1));
  assign need_row = (yi > win_row) && (win_row < ROW_MAX);

  // col_p1 is the tap column plus one, so column -1 shows up as zero without signed math.
  // NOTE: col_addr is assigned on every path, so this block stays purely combinational.
  always_comb begin
    col_p1 = {1'b0, xi} + CW'(tap_cnt);
    if (col_p1 == '0)          col_addr = '0;
    else if (col_p1 > COL_LIM) col_addr = COL_MAX;
    else                       col_addr = ADDR_W'(col_p1 - CW'(1));
  end

  // NOTE: every register here uses <=, so all branches compute from pre-edge values.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= ST_IDLE;
      x_acc      <= '0;
      y_acc      <= '0;
      win_row    <= '0;
      line_cnt   <= '0;
      pix_cnt    <= '0;
      tap_cnt    <= '0;
      drn_cnt    <= '0;
      frame_done <= 1'b0;
      rd_enb     <= 1'b0;
      rd_addr    <= '0;
      rd_sel     <= 1'b0;
      busy       <= 1'b0;
      err_ovr    <= 1'b0;
      iss_idx    <= '0;
      iss_fx     <= '0;
      iss_fy     <= '0;
      iss_sol    <= 1'b0;
      iss_eol    <= 1'b0;
    end else begin
      rd_enb  <= 1'b0;
      rd_sel  <= 1'b0;
      iss_sol <= 1'b0;
      iss_eol <= 1'b0;
      if (bus.frame_start) begin
        // Aborts any line; reads already issued still drain through the tag pipe.
        state      <= ST_IDLE;
        x_acc      <= '0;
        y_acc      <= '0;
        win_row    <= '0;
        line_cnt   <= '0;
        pix_cnt    <= '0;
        tap_cnt    <= '0;
        drn_cnt    <= '0;
        frame_done <= 1'b0;
        busy       <= 1'b0;
        err_ovr    <= 1'b0;
      end else begin
        if (bus.line_req && state != ST_IDLE) err_ovr <= 1'b1;
        case (state)
          ST_IDLE: begin
            if (bus.line_req && !frame_done) begin
              busy  <= 1'b1;
              state <= ST_ADV;
            end
          end
          ST_ADV: begin
            if (!need_row) begin
              state <= ST_WAIT_RDY;
            end else if (bus.ram_ready) begin
              rd_sel  <= 1'b1;
              win_row <= win_row + 1'b1;
              state   <= ST_GAP;
            end
          end
          ST_GAP:      state <= ST_ADV;
          ST_WAIT_RDY: if (bus.ram_ready) state <= ST_SCAN;
          ST_SCAN: begin
            rd_enb  <= 1'b1;
            rd_addr <= col_addr;
            iss_idx <= tap_cnt;
            iss_fx  <= x_acc[FRAC-1:0];
            iss_fy  <= y_acc[FRAC-1:0];
            iss_sol <= (pix_cnt == '0) && (tap_cnt == 2'd0);
            iss_eol <= last_pix && (tap_cnt == 2'd3);
            tap_cnt <= tap_cnt + 1'b1;
            if (tap_cnt == 2'd3) begin
              x_acc <= x_acc + STEP_X;
              if (last_pix) begin
                pix_cnt <= '0;
                state   <= ST_DRAIN;
              end else begin
                pix_cnt <= pix_cnt + 1'b1;
              end
            end
          end
          ST_DRAIN: begin
            if (drn_cnt == DRN_W'(RD_LAT - 1)) begin
              drn_cnt <= '0;
              state   <= ST_LDONE;
            end else begin
              drn_cnt <= drn_cnt + 1'b1;
            end
          end
          ST_LDONE: begin
            y_acc <= y_acc + STEP_Y;
            x_acc <= '0;
            busy  <= 1'b0;
            state <= ST_IDLE;
            if (line_cnt == LINE_W'(OUT_H - 1)) begin
              line_cnt   <= '0;
              frame_done <= 1'b1;
            end else begin
              line_cnt <= line_cnt + 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  logic [TAG_W-1:0] tag_in, tag_out;
  assign tag_in = {rd_enb, iss_idx, iss_fx, iss_fy, iss_sol, iss_eol};

  bicintp_tap_dly #(.W(TAG_W), .DEPTH(RD_LAT)) u_tap_dly (
    .sys_clk (sys_clk),
    .clr     (sys_rst),
    .din     (tag_in),
    .dout    (tag_out)
  );

  assign {bus.tap_vld, bus.tap_idx, bus.tap_fx, bus.tap_fy, bus.tap_sol, bus.tap_eol} = tag_out;
  assign bus.ram_rd_enb  = rd_enb;
  assign bus.ram_rd_addr = rd_addr;
  assign bus.ram_rd_sel  = rd_sel;
  assign bus.busy        = busy;
  assign bus.err_ovr     = err_ovr;
endmodule

// File: tb/tb_bicintp_rd_ctrl.sv
// Scoreboard bench for bicintp_rd_ctrl on a scaled-down geometry with the same
// 160/256 step ratios as 640x480 -> 1024x768, so a full frame fits in a short run.
module tb_bicintp_rd_ctrl;
  localparam int SRC_W    = 40;
  localparam int SRC_H    = 30;
  localparam int OUT_W    = 64;
  localparam int OUT_H    = 48;
  localparam int FRAC     = 8;
  localparam int RD_LAT   = 3;
  localparam int STEP_X   = (SRC_W << FRAC) / OUT_W;
  localparam int STEP_Y   = (SRC_H << FRAC) / OUT_H;
  localparam int MASK     = (1 << FRAC) - 1;
  localparam int TAPS     = 4 * OUT_W;
  localparam int LINE_CYC = 4 * OUT_W + RD_LAT + 3;

  logic sys_clk = 1'b0;
  logic sys_rst;

  bicintp_rd_ctrl_if #(.FRAC(FRAC)) bus ();

  bicintp_rd_ctrl #(
    .SRC_W(SRC_W), .SRC_H(SRC_H), .OUT_W(OUT_W), .OUT_H(OUT_H),
    .FRAC(FRAC), .RD_LAT(RD_LAT)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  always #4 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [1:0]      idx;
    logic [FRAC-1:0] fx;
    logic [FRAC-1:0] fy;
    logic            sol;
    logic            eol;
  } tap_t;

  logic [9:0] exp_addr_q[$];
  tap_t       exp_tap_q[$];
  int   n_tests = 0, n_fail = 0, cyc = 0;
  int   rd_seen = 0, tap_seen = 0, sel_seen = 0, sol_fy = -1;
  logic prev_sel = 1'b0;

  // Expected reads and taps for one full output line, derived from the coordinate maths.
  task automatic push_line(input int line);
    int fy, xa, xi, c;
    tap_t e;
    fy = (line * STEP_Y) & MASK;
    for (int p = 0; p < OUT_W; p++) begin
      xa = p * STEP_X;
      xi = xa >> FRAC;
      for (int t = 0; t < 4; t++) begin
        c = xi + t - 1;
        if (c < 0) c = 0;
        if (c > SRC_W - 1) c = SRC_W - 1;
        exp_addr_q.push_back(10'(c));
        e.idx = 2'(t);
        e.fx  = FRAC'(xa & MASK);
        e.fy  = FRAC'(fy);
        e.sol = (p == 0) && (t == 0);
        e.eol = (p == OUT_W - 1) && (t == 3);
        exp_tap_q.push_back(e);
      end
    end
  endtask

  // Advance to the next falling edge and score whatever the DUT presents there.
  task automatic cycle();
    tap_t       got, e;
    logic [9:0] ea;
    @(negedge sys_clk);
    cyc++;
    if (bus.ram_rd_enb === 1'b1) begin
      rd_seen++;
      n_tests++;
      if (exp_addr_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_addr: read of column %0d issued, none required", bus.ram_rd_addr);
      end else begin
        ea = exp_addr_q.pop_front();
        if (bus.ram_rd_addr !== ea) begin
          n_fail++;
          $display("FAIL rd_addr: read %0d got column %0d, required %0d", rd_seen, bus.ram_rd_addr, ea);
        end
      end
    end
    if (bus.tap_vld === 1'b1) begin
      got = {bus.tap_idx, bus.tap_fx, bus.tap_fy, bus.tap_sol, bus.tap_eol};
      tap_seen++;
      n_tests++;
      if (bus.tap_sol) sol_fy = int'(bus.tap_fy);
      if (exp_tap_q.size() == 0) begin
        n_fail++;
        $display("FAIL tap: tap_vld with idx=%0d, none required", bus.tap_idx);
      end else begin
        e = exp_tap_q.pop_front();
        if (got !== e) begin
          n_fail++;
          $display("FAIL tap: tap %0d got idx/fx/fy/sol/eol=%0d/%0d/%0d/%0b/%0b, required %0d/%0d/%0d/%0b/%0b",
                   tap_seen, got.idx, got.fx, got.fy, got.sol, got.eol, e.idx, e.fx, e.fy, e.sol, e.eol);
        end
      end
    end
    if (bus.ram_rd_sel === 1'b1) begin
      sel_seen++;
      n_tests++;
      if (prev_sel || bus.ram_rd_enb) begin
        n_fail++;
        $display("FAIL rd_sel_spacing: rd_sel with prev_sel=%0b rd_enb=%0b, required 0/0", prev_sel, bus.ram_rd_enb);
      end
    end
    prev_sel = bus.ram_rd_sel;
  endtask

  task automatic pulse_line();
    bus.line_req = 1'b1;
    cycle();
    bus.line_req = 1'b0;
  endtask

  task automatic pulse_frame();
    bus.frame_start = 1'b1;
    cycle();
    bus.frame_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      cycle();
      if (bus.busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_line(input int line);
    bit ok;
    push_line(line);
    pulse_line();
    wait_idle(LINE_CYC + 64, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL line%0d_done: busy still high after %0d cycles, required low", line, LINE_CYC + 64);
    end
    n_tests++;
    if (exp_addr_q.size() != 0 || exp_tap_q.size() != 0) begin
      n_fail++;
      $display("FAIL line%0d_complete: %0d reads / %0d taps outstanding, required 0/0",
               line, exp_addr_q.size(), exp_tap_q.size());
    end
    exp_addr_q.delete();
    exp_tap_q.delete();
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    repeat (3) cycle();
    n_tests++;
    if ({bus.ram_rd_enb, bus.ram_rd_sel, bus.busy, bus.err_ovr} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: enb/sel/busy/err=%b, required 0000",
               {bus.ram_rd_enb, bus.ram_rd_sel, bus.busy, bus.err_ovr});
    end
    n_tests++;
    if (bus.ram_rd_addr !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_addr: got %0d, required 0", bus.ram_rd_addr);
    end
    n_tests++;
    if ({bus.tap_vld, bus.tap_idx, bus.tap_fx, bus.tap_fy, bus.tap_sol, bus.tap_eol} !== '0) begin
      n_fail++;
      $display("FAIL reset_tap: vld=%0b idx=%0d fx=%0d fy=%0d, required all 0",
               bus.tap_vld, bus.tap_idx, bus.tap_fx, bus.tap_fy);
    end
    sys_rst = 1'b0;
    cycle();
  endtask

  task automatic test_line0();
    int  c0;
    bit  ok;
    pulse_frame();
    rd_seen = 0; tap_seen = 0; sel_seen = 0;
    push_line(0);
    c0 = cyc;
    pulse_line();
    n_tests++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_rise: busy=%b one cycle after line_req, required 1", bus.busy);
    end
    wait_idle(LINE_CYC + 64, ok);
    n_tests++;
    if (!ok || (cyc - c0 - 1) != LINE_CYC) begin
      n_fail++;
      $display("FAIL line_time: busy fell after %0d cycles, required %0d", cyc - c0 - 1, LINE_CYC);
    end
    n_tests++;
    if (tap_seen != TAPS || rd_seen != TAPS || sel_seen != 0) begin
      n_fail++;
      $display("FAIL line0_counts: taps=%0d reads=%0d sel=%0d, required %0d/%0d/0",
               tap_seen, rd_seen, sel_seen, TAPS, TAPS);
    end
    n_tests++;
    if (exp_addr_q.size() != 0 || exp_tap_q.size() != 0) begin
      n_fail++;
      $display("FAIL line0_complete: %0d reads / %0d taps outstanding, required 0/0",
               exp_addr_q.size(), exp_tap_q.size());
    end
    exp_addr_q.delete();
    exp_tap_q.delete();
  endtask

  task automatic test_full_frame();
    int rd0;
    pulse_frame();
    sel_seen = 0;
    for (int n = 0; n < OUT_H; n++) begin
      run_line(n);
      if (n == 1) begin
        n_tests++;
        if (sol_fy != STEP_Y) begin
          n_fail++;
          $display("FAIL line1_fy: tap_fy=%0d, required %0d", sol_fy, STEP_Y);
        end
      end
    end
    n_tests++;
    if (sel_seen != SRC_H - 1) begin
      n_fail++;
      $display("FAIL frame_sel_count: %0d rd_sel pulses, required %0d", sel_seen, SRC_H - 1);
    end
    rd0 = rd_seen;
    pulse_line();
    repeat (8) cycle();
    n_tests++;
    if (bus.busy !== 1'b0 || bus.err_ovr !== 1'b0 || rd_seen != rd0) begin
      n_fail++;
      $display("FAIL frame_end_hold: busy=%b err=%b new_reads=%0d, required 0/0/0",
               bus.busy, bus.err_ovr, rd_seen - rd0);
    end
  endtask

  task automatic test_ready_stall();
    bit ok;
    pulse_frame();
    run_line(0);
    run_line(1);
    bus.ram_ready = 1'b0;
    sel_seen = 0; rd_seen = 0;
    push_line(2);
    pulse_line();
    repeat (50) cycle();
    n_tests++;
    if (sel_seen != 0 || rd_seen != 0 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_hold: sel=%0d reads=%0d busy=%b while not ready, required 0/0/1",
               sel_seen, rd_seen, bus.busy);
    end
    bus.ram_ready = 1'b1;
    cycle();
    n_tests++;
    if (bus.ram_rd_sel !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release: rd_sel=%b one cycle after ready, required 1", bus.ram_rd_sel);
    end
    wait_idle(LINE_CYC + 64, ok);
    n_tests++;
    if (!ok || sel_seen != 1 || exp_addr_q.size() != 0 || exp_tap_q.size() != 0) begin
      n_fail++;
      $display("FAIL stall_line: done=%0b sel=%0d outstanding=%0d, required 1/1/0",
               ok, sel_seen, exp_addr_q.size() + exp_tap_q.size());
    end
    exp_addr_q.delete();
    exp_tap_q.delete();
  endtask

  task automatic test_overrun();
    bit ok;
    pulse_frame();
    rd_seen = 0; tap_seen = 0;
    push_line(0);
    pulse_line();
    repeat (20) cycle();
    n_tests++;
    if (bus.err_ovr !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_idle: err_ovr=%b before overrun, required 0", bus.err_ovr);
    end
    pulse_line();
    n_tests++;
    if (bus.err_ovr !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_set: err_ovr=%b after line_req while busy, required 1", bus.err_ovr);
    end
    wait_idle(LINE_CYC + 64, ok);
    n_tests++;
    if (!ok || rd_seen != TAPS || tap_seen != TAPS || bus.err_ovr !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_line: done=%0b reads=%0d taps=%0d err=%b, required 1/%0d/%0d/1",
               ok, rd_seen, tap_seen, bus.err_ovr, TAPS, TAPS);
    end
    exp_addr_q.delete();
    exp_tap_q.delete();
    pulse_frame();
    n_tests++;
    if (bus.err_ovr !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_clear: err_ovr=%b after frame_start, required 0", bus.err_ovr);
    end
    bus.frame_start = 1'b1;
    bus.line_req    = 1'b1;
    cycle();
    bus.frame_start = 1'b0;
    bus.line_req    = 1'b0;
    cycle();
    n_tests++;
    if (bus.busy !== 1'b0 || bus.err_ovr !== 1'b0) begin
      n_fail++;
      $display("FAIL fs_priority: busy=%b err=%b after simultaneous frame_start/line_req, required 0/0",
               bus.busy, bus.err_ovr);
    end
  endtask

  task automatic test_reset_mid_scan();
    pulse_frame();
    push_line(0);
    pulse_line();
    repeat (40) cycle();
    sys_rst = 1'b1;
    exp_addr_q.delete();
    exp_tap_q.delete();
    cycle();
    n_tests++;
    if (bus.ram_rd_enb !== 1'b0 || bus.busy !== 1'b0 || bus.tap_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid: enb=%b busy=%b tap_vld=%b after reset edge, required 0/0/0",
               bus.ram_rd_enb, bus.busy, bus.tap_vld);
    end
    sys_rst = 1'b0;
    rd_seen = 0; tap_seen = 0;
    repeat (20) cycle();
    n_tests++;
    if (rd_seen != 0 || tap_seen != 0) begin
      n_fail++;
      $display("FAIL rst_quiet: reads=%0d taps=%0d after reset, required 0/0", rd_seen, tap_seen);
    end
  endtask

  task automatic test_frame_abort();
    pulse_frame();
    run_line(0);
    run_line(1);
    push_line(2);
    pulse_line();
    repeat (40) cycle();
    pulse_frame();
    n_tests++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: busy=%b after mid-line frame_start, required 0", bus.busy);
    end
    repeat (RD_LAT + 1) cycle();
    exp_addr_q.delete();
    exp_tap_q.delete();
    sel_seen = 0;
    run_line(0);
    run_line(1);
    run_line(2);
    n_tests++;
    if (sel_seen != 1 || bus.err_ovr !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_restart: sel=%0d err=%b over lines 0..2, required 1/0", sel_seen, bus.err_ovr);
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    sys_rst         = 1'b1;
    bus.frame_start = 1'b0;
    bus.line_req    = 1'b0;
    bus.ram_ready   = 1'b1;
    test_reset();
    test_line0();
    test_full_frame();
    test_ready_stall();
    test_overrun();
    test_reset_mid_scan();
    test_frame_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
